// File: rtl/line_burst_assembler_if.sv
// Bundles the cache-side request, the memory burst bus and the line demux outputs.
// The slave modport is the assembler's view; the master modport is its environment's view.
interface line_burst_assembler_if #(
  parameter int line_width = 256,
  parameter int beat_width = 64
);
  logic                  req_valid;
  logic                  req_write;
  logic                  req_sel;
  logic [31:0]           req_addr;
  logic [line_width-1:0] req_wdata;
  logic                  req_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_addr;
  logic [beat_width-1:0] mem_wdata;
  logic                  mem_resp;
  logic [beat_width-1:0] mem_rdata;
  logic [line_width-1:0] line_out;
  logic                  line_sel;
  logic                  line_valid;

  modport master (
    output req_valid, req_write, req_sel, req_addr, req_wdata, mem_resp, mem_rdata,
    input  req_ready, mem_read, mem_write, mem_addr, mem_wdata, line_out, line_sel, line_valid
  );

  modport slave (
    input  req_valid, req_write, req_sel, req_addr, req_wdata, mem_resp, mem_rdata,
    output req_ready, mem_read, mem_write, mem_addr, mem_wdata, line_out, line_sel, line_valid
  );
endinterface

// File: rtl/line_burst_assembler.sv
// Turns one cache-line request into a burst of memory beats: fills assemble line_out beat by
// beat, write-backs stream the captured line out, and either ends with a one-cycle line_valid.
module line_burst_assembler #(
  parameter int line_width = 256,
  parameter int beat_width = 64
) (
  input logic                   clk,
  input logic                   rst,
  line_burst_assembler_if.slave bus
);
  localparam int beats    = line_width / beat_width;
  localparam int kw       = $clog2(beats);
  localparam int off_bits = $clog2(line_width / 8);
  localparam logic [kw-1:0] last_beat = kw'(beats - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state, state_next;
  logic [kw-1:0]         k;
  logic [31:0]           addr_q;
  logic [line_width-1:0] wline_q;
  logic [line_width-1:0] line_q;
  logic                  sel_q;
  logic                  accept;
  logic                  beat;

  assign accept = (state == IDLE) && bus.req_valid;
  assign beat   = ((state == READ) || (state == WRITE)) && bus.mem_resp;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake flags are pure functions of the state so they can never disagree with it.
  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.line_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = bus.req_write ? WRITE : READ;
      end
      READ: begin
        bus.mem_read = 1'b1;
        if (bus.mem_resp && (k == last_beat)) state_next = DONE;
      end
      WRITE: begin
        bus.mem_write = 1'b1;
        if (bus.mem_resp && (k == last_beat)) state_next = DONE;
      end
      DONE: begin
        bus.line_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The beat counter wraps to zero on its own after the last beat because beats is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      line_q  <= '0;
      sel_q   <= 1'b0;
    end else if (accept) begin
      k       <= '0;
      addr_q  <= {bus.req_addr[31:off_bits], {off_bits{1'b0}}};
      sel_q   <= bus.req_sel;
      wline_q <= bus.req_wdata;
    end else if (beat) begin
      if (state == READ) line_q[k*beat_width +: beat_width] <= bus.mem_rdata;
      k <= k + 1'b1;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = (state == WRITE) ? wline_q[k*beat_width +: beat_width] : '0;
  assign bus.line_out  = line_q;
  assign bus.line_sel  = sel_q;
endmodule

// File: tb/tb_line_burst_assembler.sv
// Directed bench: the stimulus tasks keep a transaction-level picture of what every output must
// show, and a negedge process compares the assembler against it every cycle.
module tb_line_burst_assembler;
  localparam int lw = 256;
  localparam int bw = 64;
  localparam int nb = lw / bw;

  typedef logic [bw-1:0] beat_arr_t [nb];

  logic clk = 1'b0;
  logic rst;

  line_burst_assembler_if #(.line_width(lw), .beat_width(bw)) bus ();

  line_burst_assembler #(.line_width(lw), .beat_width(bw)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  logic          exp_ready, exp_read, exp_write, exp_sel, exp_valid;
  logic [31:0]   exp_addr;
  logic [bw-1:0] exp_wdata;
  logic [lw-1:0] exp_line;

  int            cyc       = 0;
  int            acc_cyc   = 0;
  int            valid_cyc = 0;
  int            pulses    = 0;
  logic [bw-1:0] wr_beats[$];

  localparam logic [31:0] busy_addr = 32'hDEAD_BEEF;
  localparam logic [lw-1:0] busy_line = {4{64'h5A5A_A5A5_0F0F_F0F0}};

  task automatic checkOne(input string name, input logic [lw-1:0] got, input logic [lw-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkOne("req_ready", bus.req_ready, exp_ready);
    checkOne("mem_read", bus.mem_read, exp_read);
    checkOne("mem_write", bus.mem_write, exp_write);
    checkOne("rd_wr_exclusive", bus.mem_read & bus.mem_write, 1'b0);
    checkOne("mem_addr", bus.mem_addr, exp_addr);
    checkOne("line_out", bus.line_out, exp_line);
    checkOne("line_sel", bus.line_sel, exp_sel);
    checkOne("line_valid", bus.line_valid, exp_valid);
    if (exp_write) checkOne("mem_wdata", bus.mem_wdata, exp_wdata);
  endtask

  // Sample mid-cycle: per-cycle comparison plus accept/pulse/beat bookkeeping taken from the DUT.
  always @(negedge clk) begin
    cyc++;
    if (check_en) checkOutput();
    if (!rst && bus.req_ready && bus.req_valid) acc_cyc = cyc;
    if (bus.line_valid) begin
      valid_cyc = cyc;
      pulses++;
    end
    if (bus.mem_write && bus.mem_resp) wr_beats.push_back(bus.mem_wdata);
  end

  task automatic applyStimulus(input logic r, input logic v, input logic w, input logic s,
                               input logic [31:0] a, input logic [lw-1:0] wd,
                               input logic resp, input logic [bw-1:0] rd);
    rst           = r;
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_sel   = s;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.mem_resp  = resp;
    bus.mem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic expectReset();
    exp_ready = 1'b1;
    exp_read  = 1'b0;
    exp_write = 1'b0;
    exp_sel   = 1'b0;
    exp_valid = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_line  = '0;
  endtask

  // One request; memory answers one cycle after it first sees the burst, optionally stalling
  // before beat stall_at, or the burst is cut by reset before beat abort_at.
  task automatic runBurst(input bit wr, input bit sel, input logic [31:0] addr,
                          input logic [lw-1:0] wline, input beat_arr_t rd,
                          input int stall_at, input int stall_len, input int abort_at,
                          input bit busy_req);
    applyStimulus(1'b0, 1'b1, wr, sel, addr, wline, 1'b0, '0);
    exp_ready = 1'b0;
    exp_read  = !wr;
    exp_write = wr;
    exp_addr  = addr & ~32'h1F;
    exp_sel   = sel;
    exp_wdata = wline[bw-1:0];
    applyStimulus(1'b0, busy_req, 1'b1, ~sel, busy_addr, busy_line, 1'b0, 64'hBAD0);
    for (int b = 0; b < nb; b++) begin
      if (b == abort_at) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        expectReset();
        return;
      end
      if (b == stall_at)
        repeat (stall_len) applyStimulus(1'b0, busy_req, 1'b1, ~sel, busy_addr, busy_line, 1'b0, 64'hBAD1);
      applyStimulus(1'b0, busy_req, 1'b1, ~sel, busy_addr, busy_line, 1'b1, rd[b]);
      if (!wr) exp_line[b*bw +: bw] = rd[b];
      if (b < nb - 1) exp_wdata = wline[(b+1)*bw +: bw];
    end
    exp_read  = 1'b0;
    exp_write = 1'b0;
    exp_valid = 1'b1;
    applyStimulus(1'b0, busy_req, 1'b1, ~sel, busy_addr, busy_line, 1'b1, 64'hFFFF_0000_FFFF_0000);
    exp_valid = 1'b0;
    exp_ready = 1'b1;
  endtask

  initial begin
    beat_arr_t     fill_a, fill_b, fill_c, junk;
    logic [lw-1:0] fill_a_line, wb_line;
    logic [bw-1:0] d [nb];
    int            p0;

    fill_a = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    fill_b = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
               64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0};
    fill_c = '{64'hC0C0_0000_0000_00C0, 64'hC1C1_0000_0000_00C1,
               64'hC2C2_0000_0000_00C2, 64'hC3C3_0000_0000_00C3};
    junk   = '{64'hEEEE, 64'hEEEE, 64'hEEEE, 64'hEEEE};
    d      = '{64'hD0D0_0000_0000_00D0, 64'hD1D1_0000_0000_00D1,
               64'hD2D2_0000_0000_00D2, 64'hD3D3_0000_0000_00D3};
    fill_a_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wb_line = {d[3], d[2], d[1], d[0]};

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    expectReset();
    check_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);

    $display("[TB] stray beats in IDLE");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 64'hDEAD);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 64'hBEEF);

    $display("[TB] read fill");
    p0 = pulses;
    runBurst(1'b0, 1'b1, 32'h0000_1234, '0, fill_a, -1, 0, -1, 1'b0);
    checkOne("fill_latency", valid_cyc - acc_cyc, 6);
    checkOne("fill_line", bus.line_out, fill_a_line);
    checkOne("fill_addr", bus.mem_addr, 32'h0000_1220);
    checkOne("fill_sel", bus.line_sel, 1'b1);
    checkOne("fill_pulses", pulses - p0, 1);

    $display("[TB] write-back");
    wr_beats.delete();
    p0 = pulses;
    runBurst(1'b1, 1'b0, 32'h8000_0047, wb_line, junk, -1, 0, -1, 1'b0);
    checkOne("wb_beat_count", wr_beats.size(), nb);
    for (int i = 0; i < nb && i < wr_beats.size(); i++) checkOne("wb_beat", wr_beats[i], d[i]);
    checkOne("wb_line_kept", bus.line_out, fill_a_line);
    checkOne("wb_pulses", pulses - p0, 1);

    $display("[TB] different fill, then stalled fill");
    runBurst(1'b0, 1'b0, 32'h0000_0FFF, '0, fill_b, -1, 0, -1, 1'b0);
    runBurst(1'b0, 1'b1, 32'h0000_1234, '0, fill_a, 2, 3, -1, 1'b0);
    checkOne("stall_latency", valid_cyc - acc_cyc, 9);
    checkOne("stall_line", bus.line_out, fill_a_line);

    $display("[TB] reset mid-burst");
    p0 = pulses;
    runBurst(1'b0, 1'b1, 32'h0000_4000, '0, fill_c, -1, 0, 2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOne("abort_pulses", pulses - p0, 0);
    runBurst(1'b0, 1'b0, 32'h0000_4010, '0, fill_b, -1, 0, -1, 1'b0);
    checkOne("after_abort_latency", valid_cyc - acc_cyc, 6);

    $display("[TB] request while busy");
    runBurst(1'b0, 1'b0, 32'h0000_2000, '0, fill_c, 1, 2, -1, 1'b1);
    wr_beats.delete();
    runBurst(1'b1, 1'b1, busy_addr, busy_line, junk, -1, 0, -1, 1'b0);
    checkOne("busy_addr", bus.mem_addr, 32'hDEAD_BEE0);
    checkOne("busy_wb_beats", wr_beats.size(), nb);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
